// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one bitwise logic datapath (OR/AND/XOR/pass A) between NREQ requesters.
// Round-robin arbitration, valid/ready on each request port and a single registered
// response slot tagged with the index of the requester that produced it.
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*2-1:0] req_op_i,
  input  logic [NREQ*DW-1:0] req_a_i,
  input  logic [NREQ*DW-1:0] req_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [DW-1:0]     rsp_data_o
);

  // Occupancy of the output register
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  logic [0:0]     state_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rsp_id_q;
  logic [DW-1:0]  rsp_data_q;

  logic [1:0]     op_arr [NREQ];
  logic [DW-1:0]  a_arr  [NREQ];
  logic [DW-1:0]  b_arr  [NREQ];

  logic           can_accept;
  logic           grant_found;
  logic           grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [DW-1:0]  result;

  // Unpack the flat per-requester buses so the winner can be selected by index
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign op_arr[k] = req_op_i[k*2 +: 2];
    assign a_arr[k]  = req_a_i[k*DW +: DW];
    assign b_arr[k]  = req_b_i[k*DW +: DW];
  end

  // A new request can be taken when the slot is empty or is being drained this cycle
  assign can_accept = (state_q == EMPTY) | rsp_ready_i;
  assign grant      = rst_ni & can_accept & grant_found;

  // Round-robin search: first valid requester starting at rr_q, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_q) + 32'(i)) % 32'(NREQ));
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot ready towards the winning requester, zero when nothing is granted
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Bitwise operation on the winner's operands
  always_comb begin
    unique case (op_arr[grant_idx])
      OP_OR:   result = a_arr[grant_idx] | b_arr[grant_idx];
      OP_AND:  result = a_arr[grant_idx] & b_arr[grant_idx];
      OP_XOR:  result = a_arr[grant_idx] ^ b_arr[grant_idx];
      default: result = a_arr[grant_idx];
    endcase
  end

  // Output slot, occupancy and round-robin pointer; drain and capture may share one edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      rr_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else if (grant) begin
      state_q    <= FULL;
      rsp_id_q   <= grant_idx;
      rsp_data_q <= result;
      rr_q       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (state_q == FULL && rsp_ready_i) begin
      state_q    <= EMPTY;
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter
// Directed and randomized stimulus against a queue-based reference model; a separate
// monitor pops expected responses and compares them with what the arbiter presents.
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = $clog2(NREQ);

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic               clk_i;
  logic               rst_ni;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ*2-1:0]  req_op_i;
  logic [NREQ*DW-1:0] req_a_i;
  logic [NREQ*DW-1:0] req_b_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [IDW-1:0]     rsp_id_o;
  logic [DW-1:0]      rsp_data_o;

  int   total = 0;
  int   bad   = 0;
  rsp_t exp_q[$];
  int   model_rr = 0;

  logic [NREQ-1:0]    r_vld;
  logic [NREQ*2-1:0]  r_ops;
  logic [NREQ*DW-1:0] r_as;
  logic [NREQ*DW-1:0] r_bs;
  int                 granted;

  logic_unit_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] refOp(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Drive one cycle of inputs, predict the grant, check req_ready_o and queue the result.
  // The monitor has already retired the held result by +3 if it drains this cycle,
  // so an empty queue means the slot can take a new request.
  task automatic applyStimulus(input logic [NREQ-1:0] vld, input logic [NREQ*2-1:0] ops,
                               input logic [NREQ*DW-1:0] as, input logic [NREQ*DW-1:0] bs,
                               input logic rready, output int gnt);
    logic [NREQ-1:0] exp_ready;
    rsp_t r;
    @(posedge clk_i);
    #1;
    req_valid_i = vld;
    req_op_i    = ops;
    req_a_i     = as;
    req_b_i     = bs;
    rsp_ready_i = rready;
    #2;
    gnt = -1;
    if (exp_q.size() == 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (model_rr + i) % NREQ;
        if (gnt < 0 && vld[k]) gnt = k;
      end
    end
    exp_ready = '0;
    if (gnt >= 0) begin
      exp_ready[gnt] = 1'b1;
      r.id   = gnt;
      r.data = refOp(ops[gnt*2 +: 2], as[gnt*DW +: DW], bs[gnt*DW +: DW]);
      exp_q.push_back(r);
      model_rr = (gnt + 1) % NREQ;
    end
    checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
  endtask

  // Monitor: compare the presented response with the queue head, retire it on handshake
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_ni) begin
        checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(exp_q.size() != 0));
        if (rsp_valid_o && exp_q.size() != 0) begin
          checkOutput("rsp_id", 64'(rsp_id_o), 64'(exp_q[0].id));
          checkOutput("rsp_data", 64'(rsp_data_o), 64'(exp_q[0].data));
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    #1;
    checkOutput("reset_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("reset_id", 64'(rsp_id_o), 64'd0);
    checkOutput("reset_data", 64'(rsp_data_o), 64'd0);
    checkOutput("reset_ready", 64'(req_ready_o), 64'd0);
    #11;
    rst_ni = 1'b1;

    // Fairness from reset: all valid, consumer always ready
    r_ops = '0;
    r_as = '0;
    r_bs = '0;
    for (int k = 0; k < NREQ; k++) begin
      r_ops[k*2 +: 2] = 2'(k);
      r_as[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);
      r_bs[k*DW +: DW] = 32'h0F0F_F0F0 ^ 32'(k << 8);
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus('1, r_ops, r_as, r_bs, 1'b1, granted);
      checkOutput("fair_id", 64'(granted), 64'(c % NREQ));
    end

    // Single request from requester 2, OR
    r_ops = '0;
    r_as = '0;
    r_bs = '0;
    r_as[2*DW +: DW] = 32'h0000_F0F0;
    r_bs[2*DW +: DW] = 32'h0F0F_0000;
    applyStimulus(4'b0100, r_ops, r_as, r_bs, 1'b1, granted);

    // Requester 0 with AND, XOR, pass A back to back
    r_as = '0;
    r_bs = '0;
    r_as[0 +: DW] = 32'hFFFF_0000;
    r_bs[0 +: DW] = 32'h00FF_FF00;
    for (int op = 1; op < 4; op++) begin
      r_ops = '0;
      r_ops[1:0] = 2'(op);
      applyStimulus(4'b0001, r_ops, r_as, r_bs, 1'b1, granted);
    end

    // Backpressure: capture one, stall five cycles, then release
    for (int k = 0; k < NREQ; k++) begin
      r_ops[k*2 +: 2] = 2'(3 - k);
      r_as[k*DW +: DW] = 32'h1234_0000 | 32'(k * 17);
      r_bs[k*DW +: DW] = 32'hFF00_00FF;
    end
    applyStimulus('1, r_ops, r_as, r_bs, 1'b1, granted);
    for (int c = 0; c < 5; c++) applyStimulus('1, r_ops, r_as, r_bs, 1'b0, granted);
    applyStimulus('1, r_ops, r_as, r_bs, 1'b1, granted);
    applyStimulus('0, r_ops, r_as, r_bs, 1'b1, granted);

    // Reset while holding a result from requester 1
    applyStimulus(4'b0010, r_ops, r_as, r_bs, 1'b0, granted);
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("midreset_ready", 64'(req_ready_o), 64'd0);
    exp_q.delete();
    model_rr = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    applyStimulus('1, r_ops, r_as, r_bs, 1'b1, granted);
    checkOutput("post_reset_grant", 64'(granted), 64'd0);

    // Sparse requesters 1 and 3 with the pointer at 2
    applyStimulus(4'b0010, r_ops, r_as, r_bs, 1'b1, granted);
    applyStimulus(4'b1010, r_ops, r_as, r_bs, 1'b1, granted);
    checkOutput("sparse_a", 64'(granted), 64'd3);
    applyStimulus(4'b1010, r_ops, r_as, r_bs, 1'b1, granted);
    checkOutput("sparse_b", 64'(granted), 64'd1);
    applyStimulus(4'b1010, r_ops, r_as, r_bs, 1'b1, granted);
    checkOutput("sparse_c", 64'(granted), 64'd3);

    // Random traffic: requesters hold their request until granted
    r_vld = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!r_vld[k] && $urandom_range(0, 2) != 0) begin
          r_vld[k] = 1'b1;
          r_ops[k*2 +: 2] = 2'($urandom_range(0, 3));
          r_as[k*DW +: DW] = $urandom;
          r_bs[k*DW +: DW] = $urandom;
        end
      end
      applyStimulus(r_vld, r_ops, r_as, r_bs, ($urandom_range(0, 9) < 7), granted);
      if (granted >= 0) r_vld[granted] = 1'b0;
    end

    // Drain and confirm the slot empties
    applyStimulus('0, r_ops, r_as, r_bs, 1'b1, granted);
    applyStimulus('0, r_ops, r_as, r_bs, 1'b1, granted);
    @(posedge clk_i);
    #2;
    checkOutput("idle_valid", 64'(rsp_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
